// File: rtl/nn_result_argmax.sv
`default_nettype none
// ============================================================================
//  Module   : nn_result_argmax
//  Purpose  : Result collector for the single-MAC neural network accelerator.
//             Captures each FP32 dot-product result, applies ReLU, stores up
//             to NUM_OUTPUTS activations, tracks a running argmax/max and
//             raises a level interrupt once a full output layer is collected.
//             Results and status are exposed through a non-burst Avalon-MM
//             slave with registered, 1-cycle read latency.
//  Ports    : clk          - system clock
//             reset_n      - asynchronous, active-low reset
//             result_valid - one-cycle strobe, result_data valid
//             result_data  - IEEE-754 single-precision MAC result
//             address      - Avalon word address
//             read / write - Avalon strobes
//             writedata    - Avalon write data
//             readdata     - Avalon read data (registered)
//             irq          - level interrupt, high while done is pending
//  Register map (word addresses):
//             0x00 CTRL/STATUS  rd: {irq,nan,overrun,collecting,done}
//                               wr: bit0 clear/restart, bit1 irq acknowledge
//             0x01 ARGMAX, 0x02 MAX, 0x03 COUNT
//             0x10 + i          act[i], i < NUM_OUTPUTS
//  Revision : 1.0 - initial release
// ============================================================================
module nn_result_argmax #(
   parameter int NUM_OUTPUTS = 24,
   parameter int IDX_W       = 6
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        result_valid,
   input  logic [31:0] result_data,
   input  logic [7:0]  address,
   input  logic        read,
   input  logic        write,
   input  logic [31:0] writedata,
   output logic [31:0] readdata,
   output logic        irq
);

   localparam logic [IDX_W-1:0] c_last_idx = IDX_W'(NUM_OUTPUTS - 1);
   localparam logic [7:0]       c_act_base = 8'h10;

   typedef enum logic [0:0] {
      ST_COLLECT = 1'b0,
      ST_DONE    = 1'b1
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;

   logic [IDX_W-1:0]  r_count;
   logic [IDX_W-1:0]  r_argmax;
   logic [31:0]       r_max;
   logic              r_nan;
   logic              r_overrun;
   logic              r_irq;
   logic [31:0]       r_readdata;
   logic [31:0]       r_act [NUM_OUTPUTS];

   logic              w_ctrl_wr;
   logic              w_clear;
   logic              w_ack;
   logic              w_is_nan;
   logic [31:0]       w_relu;
   logic              w_accept;
   logic              w_dropped;
   logic              w_last;
   logic              w_take_max;
   logic [31:0]       w_rd_mux;
   logic              w_unused_wdata;

   // Only the two low CTRL bits carry meaning.
   assign w_unused_wdata = &{1'b0, writedata[31:2]};

   // ---------------------------------------------------------------------
   // Control decode. A clear outranks a coincident sample: the sample is
   // dropped and does not count as an overrun.
   // ---------------------------------------------------------------------
   assign w_ctrl_wr = write && (address == 8'h00);
   assign w_clear   = w_ctrl_wr && writedata[0];
   assign w_ack     = w_ctrl_wr && writedata[1];

   // ---------------------------------------------------------------------
   // ReLU. Negative values (including -0 and -Inf) and NaNs collapse to +0;
   // +Inf passes through unchanged.
   // ---------------------------------------------------------------------
   assign w_is_nan = (result_data[30:23] == 8'hFF) && (result_data[22:0] != 23'd0);
   assign w_relu   = (result_data[31] || w_is_nan) ? 32'd0 : result_data;

   assign w_accept  = result_valid && (r_state == ST_COLLECT) && !w_clear;
   assign w_dropped = result_valid && (r_state == ST_DONE) && !w_clear;
   assign w_last    = (r_count == c_last_idx);

   // Post-ReLU values are non-negative, so the magnitude bits order like
   // unsigned integers. Strict greater-than keeps the lowest index on ties;
   // the first sample of a layer always loads.
   assign w_take_max = (r_count == '0) || (w_relu[30:0] > r_max[30:0]);

   // ---------------------------------------------------------------------
   // Layer state machine
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= ST_COLLECT;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      if (w_clear) begin
         w_state_nxt = ST_COLLECT;
      end else if (w_accept && w_last) begin
         w_state_nxt = ST_DONE;
      end
   end

   // ---------------------------------------------------------------------
   // Count, running argmax/max and sticky status flags
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_count   <= '0;
         r_argmax  <= '0;
         r_max     <= 32'd0;
         r_nan     <= 1'b0;
         r_overrun <= 1'b0;
         r_irq     <= 1'b0;
      end else if (w_clear) begin
         r_count   <= '0;
         r_argmax  <= '0;
         r_max     <= 32'd0;
         r_nan     <= 1'b0;
         r_overrun <= 1'b0;
         r_irq     <= 1'b0;
      end else begin
         if (w_accept) begin
            r_count <= r_count + 1'b1;
            if (w_take_max) begin
               r_max    <= w_relu;
               r_argmax <= r_count;
            end
            if (w_is_nan) begin
               r_nan <= 1'b1;
            end
         end
         if (w_dropped) begin
            r_overrun <= 1'b1;
         end
         // A completing sample in the same cycle as an acknowledge is a new
         // done event, so it keeps the interrupt asserted.
         if (w_accept && w_last) begin
            r_irq <= 1'b1;
         end else if (w_ack) begin
            r_irq <= 1'b0;
         end
      end
   end

   // ---------------------------------------------------------------------
   // Activation storage. Clear does not wipe it; entries are overwritten as
   // the next layer arrives.
   // ---------------------------------------------------------------------
   generate
      for (genvar gi = 0; gi < NUM_OUTPUTS; gi++) begin : g_act
         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
               r_act[gi] <= 32'd0;
            end else if (w_accept && (r_count == IDX_W'(gi))) begin
               r_act[gi] <= w_relu;
            end
         end
      end
   endgenerate

   // ---------------------------------------------------------------------
   // Avalon read path
   // ---------------------------------------------------------------------
   always_comb begin
      w_rd_mux = 32'd0;
      case (address)
         8'h00: w_rd_mux = {27'd0, r_irq, r_nan, r_overrun,
                            (r_state == ST_COLLECT), (r_state == ST_DONE)};
         8'h01: w_rd_mux = 32'(r_argmax);
         8'h02: w_rd_mux = r_max;
         8'h03: w_rd_mux = 32'(r_count);
         default: begin
            for (int i = 0; i < NUM_OUTPUTS; i++) begin
               if (address == (c_act_base + 8'(i))) begin
                  w_rd_mux = r_act[i];
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_readdata <= 32'd0;
      end else if (read) begin
         r_readdata <= w_rd_mux;
      end else begin
         r_readdata <= 32'd0;
      end
   end

   assign readdata = r_readdata;
   assign irq      = r_irq;

endmodule
`default_nettype wire
